// File: rtl/edf_ic_pkg.sv
// Shared definitions for the EDF interrupt controller and its core-side taker.
// Holds the taker FSM state encoding and the deadline register layout in cfg
// space. The gateway decoder in edf_ic decodes the same offsets, so both sides
// must change together.
package edf_ic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WAIT_HI,
    TRAP,
    ACTIVE
  } state_e;

  // Each IRQ owns a 64-bit deadline split into two 32-bit words.
  localparam logic [31:0] DlLoOffset = 32'd0;
  localparam logic [31:0] DlHiOffset = 32'd4;
  localparam logic [31:0] DlStride   = 32'd8;

  // An all-ones deadline means the interrupt has no deadline at all.
  localparam logic [63:0] NoDeadline = '1;

endpackage

// File: rtl/edf_irq_taker.sv
// Core-side consumer of the EDF interrupt controller's winner handshake.
// It claims the winning IRQ and then reads that IRQ's 64-bit deadline as two
// cfg reads. It then raises a trap request and holds it until the core
// acknowledges. When the handler completes, it compares mtime against the
// deadline and flags and counts a miss.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   irq_valid_i/irq_id_i  upstream winner; irq_ready_o claims it
//   cfg_*                 read-only cfg initiator (data returns one cycle after req)
//   mtime_i               machine timer used for the deadline check
//   core_irq_en_i         core can take an interrupt now
//   trap_req_o/trap_id_o  trap request to the core, held until trap_ack_i
//   complete_i            handler finished
//   dl_miss_o/miss_cnt_o  miss pulse and saturating miss count
//   busy_o                a claimed interrupt is in flight
module edf_irq_taker
  import edf_ic_pkg::*;
#(
  parameter int          NrIrqs   = 4,
  parameter int          TsWidth  = 64,
  parameter logic [31:0] BaseAddr = 32'h0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      irq_valid_i,
  input  logic [$clog2(NrIrqs)-1:0] irq_id_i,
  output logic                      irq_ready_o,
  output logic                      cfg_req_o,
  output logic                      cfg_we_o,
  output logic [31:0]               cfg_addr_o,
  output logic [31:0]               cfg_wdata_o,
  input  logic [31:0]               cfg_rdata_i,
  input  logic [TsWidth-1:0]        mtime_i,
  input  logic                      core_irq_en_i,
  output logic                      trap_req_o,
  output logic [$clog2(NrIrqs)-1:0] trap_id_o,
  input  logic                      trap_ack_i,
  input  logic                      complete_i,
  output logic                      dl_miss_o,
  output logic [31:0]               miss_cnt_o,
  output logic                      busy_o
);

  localparam int IdWidth = $clog2(NrIrqs);

  state_e               state_q, state_d;
  logic [IdWidth-1:0]   id_q;
  logic [TsWidth-1:0]   dl_q;
  logic [31:0]          miss_cnt_q;
  logic [31:0]          id_off;
  logic                 handshake;
  logic                 late;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign id_off    = DlStride * {{(32-IdWidth){1'b0}}, id_q};
  assign handshake = irq_valid_i & irq_ready_o;
  // Unsigned compare; equality with the deadline still counts as on time.
  assign late      = (dl_q != NoDeadline) && (mtime_i > dl_q);

  always_comb begin
    state_d     = state_q;
    irq_ready_o = 1'b0;
    cfg_req_o   = 1'b0;
    cfg_addr_o  = 32'h0;
    trap_req_o  = 1'b0;
    dl_miss_o   = 1'b0;
    case (state_q)
      IDLE: begin
        irq_ready_o = irq_valid_i & core_irq_en_i;
        if (irq_valid_i & core_irq_en_i) state_d = RD_LO;
      end
      RD_LO: begin
        cfg_req_o  = 1'b1;
        cfg_addr_o = BaseAddr + id_off + DlLoOffset;
        state_d    = RD_HI;
      end
      RD_HI: begin
        cfg_req_o  = 1'b1;
        cfg_addr_o = BaseAddr + id_off + DlHiOffset;
        state_d    = WAIT_HI;
      end
      WAIT_HI: state_d = TRAP;
      TRAP: begin
        trap_req_o = 1'b1;
        // A completion seen in the same cycle as the ack is dropped on purpose.
        if (trap_ack_i) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (complete_i) begin
          state_d   = IDLE;
          dl_miss_o = late;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cfg_we_o    = 1'b0;
  assign cfg_wdata_o = 32'h0;
  assign trap_id_o   = (state_q == IDLE) ? '0 : id_q;
  assign busy_o      = (state_q != IDLE);
  assign miss_cnt_o  = miss_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      id_q    <= '0;
      dl_q    <= '0;
    end else begin
      state_q <= state_d;
      if (handshake) id_q <= irq_id_i;
      // Read data arrives the cycle after each request.
      if (state_q == RD_HI)   dl_q[31:0]  <= cfg_rdata_i;
      if (state_q == WAIT_HI) dl_q[63:32] <= cfg_rdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      miss_cnt_q <= 32'h0;
    end else if (dl_miss_o) begin
      miss_cnt_q <= sat_inc(miss_cnt_q);
    end
  end

endmodule

// File: tb/tb_edf_irq_taker.sv
// Testbench for edf_irq_taker. The cfg target is a small deadline memory that
// returns data one cycle after each request. Expected addresses and miss
// outcomes are queued at the handshake and popped when the DUT produces them.
module tb_edf_irq_taker;

  logic        clk = 1'b0;
  logic        rst;
  logic        irq_valid;
  logic [1:0]  irq_id;
  logic        irq_ready;
  logic        cfg_req;
  logic        cfg_we;
  logic [31:0] cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata = 32'hDEAD_BEEF;
  logic [63:0] mtime;
  logic        core_irq_en;
  logic        trap_req;
  logic [1:0]  trap_id;
  logic        trap_ack;
  logic        complete;
  logic        dl_miss;
  logic [31:0] miss_cnt;
  logic        busy;

  int passed = 0;
  int total  = 0;

  logic [31:0] exp_addr_q[$];
  logic        exp_miss_q[$];
  logic [63:0] dl_mem [4];

  always #5 clk = ~clk;

  edf_irq_taker dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .irq_valid_i  (irq_valid),
    .irq_id_i     (irq_id),
    .irq_ready_o  (irq_ready),
    .cfg_req_o    (cfg_req),
    .cfg_we_o     (cfg_we),
    .cfg_addr_o   (cfg_addr),
    .cfg_wdata_o  (cfg_wdata),
    .cfg_rdata_i  (cfg_rdata),
    .mtime_i      (mtime),
    .core_irq_en_i(core_irq_en),
    .trap_req_o   (trap_req),
    .trap_id_o    (trap_id),
    .trap_ack_i   (trap_ack),
    .complete_i   (complete),
    .dl_miss_o    (dl_miss),
    .miss_cnt_o   (miss_cnt),
    .busy_o       (busy)
  );

  // Deadline memory; garbage when not requested so a mistimed capture shows.
  always @(posedge clk) begin
    if (cfg_req)
      cfg_rdata <= cfg_addr[2] ? dl_mem[cfg_addr[4:3]][63:32] : dl_mem[cfg_addr[4:3]][31:0];
    else
      cfg_rdata <= 32'hDEAD_BEEF;
  end

  task automatic run_irq(input logic [1:0] id, input logic [63:0] mt,
                         input logic exp_miss, input logic [31:0] exp_cnt);
    int cyc;
    logic [31:0] ea;
    logic em;
    irq_valid   = 1'b1;
    irq_id      = id;
    core_irq_en = 1'b1;
    mtime       = mt;
    #1;
    total++;
    if (irq_ready !== 1'b1) $display("FAIL ready_id%0d: got %b want 1", id, irq_ready);
    else passed++;
    exp_addr_q.push_back(32'(id) * 8);
    exp_addr_q.push_back(32'(id) * 8 + 4);
    exp_miss_q.push_back(exp_miss);
    @(negedge clk);
    irq_valid = 1'b0;
    cyc = 1;
    while (cyc < 12 && trap_req !== 1'b1) begin
      if (cfg_req === 1'b1) begin
        total++;
        if (exp_addr_q.size() == 0) begin
          $display("FAIL cfg_addr: got %h want none", cfg_addr);
        end else begin
          ea = exp_addr_q.pop_front();
          if (cfg_addr !== ea || cfg_we !== 1'b0 || cfg_wdata !== 32'h0)
            $display("FAIL cfg_addr: got %h we=%b wd=%h want %h we=0 wd=0", cfg_addr, cfg_we, cfg_wdata, ea);
          else passed++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    total++;
    if (cyc !== 4 || exp_addr_q.size() != 0)
      $display("FAIL trap_latency: got %0d cycles (%0d addrs left) want 4 (0)", cyc, exp_addr_q.size());
    else passed++;
    total++;
    if (trap_id !== id || busy !== 1'b1)
      $display("FAIL trap_id: got %0d busy=%b want %0d busy=1", trap_id, busy, id);
    else passed++;
    exp_addr_q.delete();
    // Held without ack; then ack and complete together -> only the ack counts.
    @(negedge clk);
    total++;
    if (trap_req !== 1'b1) $display("FAIL trap_hold: got %b want 1", trap_req);
    else passed++;
    trap_ack = 1'b1;
    complete = 1'b1;
    @(negedge clk);
    trap_ack = 1'b0;
    complete = 1'b0;
    total++;
    if (trap_req !== 1'b0 || busy !== 1'b1 || miss_cnt !== exp_cnt - 32'(exp_miss) && exp_cnt != 32'hFFFF_FFFF)
      $display("FAIL active_entry: got req=%b busy=%b want req=0 busy=1", trap_req, busy);
    else passed++;
    complete = 1'b1;
    #1;
    em = exp_miss_q.pop_front();
    total++;
    if (dl_miss !== em) $display("FAIL dl_miss: got %b want %b", dl_miss, em);
    else passed++;
    @(negedge clk);
    complete = 1'b0;
    total++;
    if (busy !== 1'b0 || dl_miss !== 1'b0 || miss_cnt !== exp_cnt || trap_id !== 2'd0)
      $display("FAIL complete: got busy=%b miss=%b cnt=%h id=%0d want busy=0 miss=0 cnt=%h id=0",
               busy, dl_miss, miss_cnt, trap_id, exp_cnt);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1; irq_valid = 1'b0; irq_id = 2'd0; mtime = 64'h0;
    core_irq_en = 1'b0; trap_ack = 1'b0; complete = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({irq_ready, cfg_req, cfg_we, cfg_addr, cfg_wdata, trap_req, trap_id, dl_miss, miss_cnt, busy} !== '0)
      $display("FAIL reset_outputs: got ready=%b req=%b addr=%h trap=%b id=%0d miss=%b cnt=%h busy=%b want all 0",
               irq_ready, cfg_req, cfg_addr, trap_req, trap_id, dl_miss, miss_cnt, busy);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_no_miss();
    dl_mem[2] = 64'h0000_0000_0000_0100;
    run_irq(2'd2, 64'h80, 1'b0, 32'd0);
  endtask

  task automatic test_miss_boundary();
    run_irq(2'd2, 64'h101, 1'b1, 32'd1);
    run_irq(2'd2, 64'h100, 1'b0, 32'd1);
    dl_mem[3] = 64'h0000_0001_0000_0000;
    run_irq(2'd3, 64'h0000_0001_0000_0001, 1'b1, 32'd2);
  endtask

  task automatic test_no_deadline();
    dl_mem[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    run_irq(2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 32'd2);
  endtask

  task automatic test_enable_gate_and_reset_in_trap();
    irq_valid   = 1'b1;
    irq_id      = 2'd3;
    core_irq_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (irq_ready !== 1'b0 || busy !== 1'b0)
        $display("FAIL en_gate_%0d: got ready=%b busy=%b want 0 0", i, irq_ready, busy);
      else passed++;
      @(negedge clk);
    end
    core_irq_en = 1'b1;
    #1;
    total++;
    if (irq_ready !== 1'b1) $display("FAIL en_release: got %b want 1", irq_ready);
    else passed++;
    @(negedge clk);
    irq_valid = 1'b0;
    total++;
    if (busy !== 1'b1) $display("FAIL en_claim: got busy=%b want 1", busy);
    else passed++;
    repeat (3) @(negedge clk);
    total++;
    if (trap_req !== 1'b1 || trap_id !== 2'd3)
      $display("FAIL trap_reached: got req=%b id=%0d want 1 3", trap_req, trap_id);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (trap_req !== 1'b0 || busy !== 1'b0 || miss_cnt !== 32'd0)
      $display("FAIL reset_in_trap: got req=%b busy=%b cnt=%h want 0 0 0", trap_req, busy, miss_cnt);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_saturate();
    force dut.miss_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.miss_cnt_q;
    dl_mem[0] = 64'h10;
    run_irq(2'd0, 64'h20, 1'b1, 32'hFFFF_FFFF);
  endtask

  initial begin
    test_reset();
    test_no_miss();
    test_miss_boundary();
    test_no_deadline();
    test_enable_gate_and_reset_in_trap();
    test_saturate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
